// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I fetch stage. Holds the PC, issues one word fetch at a
//                time over a req/ack handshake, buffers returned words in a
//                small prefetch FIFO and drives the IF/ID register.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // Fetch-side state
    logic [31:0]        r_pcf;
    logic [31:0]        r_req_addr;
    logic               r_pend;
    logic               r_discard;

    // Prefetch FIFO
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // IF/ID register
    logic [31:0]        r_instr_d;
    logic [31:0]        r_pc_d;
    logic [31:0]        r_pc_plus4_d;
    logic               r_valid_d;

    logic               w_room;
    logic               w_issue;
    logic               w_ack;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_target;

    // With no request outstanding the occupancy alone bounds the FIFO; an
    // in-flight word is already reserved because issue needs r_pend=0.
    assign w_room    = (r_count < c_depth);
    assign w_issue   = reset & ~r_pend & w_room & ~PCSrcE;
    assign w_ack     = r_pend & imem_ack;
    assign w_push    = w_ack & ~r_discard & ~PCSrcE;
    assign w_pop     = ~PCSrcE & ~FlushD & ~StallD & (r_count != '0);
    assign w_target  = PCTargetE & ~32'd3;

    // A raised request is held with its original address until acked
    assign imem_req  = r_pend | w_issue;
    assign imem_addr = r_pend ? r_req_addr : r_pcf;

    assign InstrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pc_plus4_d;
    assign ValidD    = r_valid_d;

    // PC register: redirect overrides sequential advance on issue
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pcf <= RESET_PC;
        end else if (PCSrcE) begin
            r_pcf <= w_target;
        end else if (w_issue) begin
            r_pcf <= r_pcf + 32'd4;
        end
    end

    // Outstanding-request tracking and wrong-path discard flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend     <= 1'b0;
            r_discard  <= 1'b0;
            r_req_addr <= '0;
        end else begin
            if (w_issue) begin
                r_pend     <= 1'b1;
                r_req_addr <= r_pcf;
            end else if (w_ack) begin
                r_pend     <= 1'b0;
            end
            // A redirect with the ack in the same cycle simply drops the
            // word; otherwise the still-outstanding response is marked stale.
            if (PCSrcE) begin
                r_discard <= r_pend & ~imem_ack;
            end else if (w_ack) begin
                r_discard <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO
    always_ff @(posedge clk) begin
        if (!reset || PCSrcE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // FIFO storage write (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_req_addr;
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    // IF/ID register, priority reset > redirect > flush > stall > pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr_d    <= NOP;
            r_pc_d       <= '0;
            r_pc_plus4_d <= 32'd4;
            r_valid_d    <= 1'b0;
        end else if (PCSrcE || FlushD) begin
            r_instr_d    <= NOP;
            r_valid_d    <= 1'b0;
        end else if (StallD) begin
            r_instr_d    <= r_instr_d;
        end else if (w_pop) begin
            r_instr_d    <= r_fifo_instr[r_rd_ptr];
            r_pc_d       <= r_fifo_pc[r_rd_ptr];
            r_pc_plus4_d <= r_fifo_pc[r_rd_ptr] + 32'd4;
            r_valid_d    <= 1'b1;
        end else begin
            r_instr_d    <= NOP;
            r_valid_d    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with a
//                variable-latency instruction memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2),
        .NOP        (c_nop)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    int          nchk = 0;
    int          nfail = 0;
    bit          busy;
    int          cnt;
    int          lat;
    int          stab_err;
    logic [31:0] raddr;
    logic        last_req;
    logic [31:0] last_addr;
    logic [31:0] vq[$];
    logic [31:0] areq[$];

    // Memory contents: a simple address-derived pattern
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive ack, observe the request, record issued IF/ID words
    task automatic cyc();
        logic stall_now;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (busy) begin
            cnt--;
            if (cnt <= 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem(raddr);
                busy       = 1'b0;
            end
        end
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (busy && reset && (imem_req !== 1'b1 || imem_addr !== raddr)) stab_err++;
        if (reset && !busy && !imem_ack && imem_req === 1'b1) begin
            busy  = 1'b1;
            cnt   = lat;
            raddr = imem_addr;
            areq.push_back(imem_addr);
        end
        stall_now = StallD;
        @(posedge clk);
        #1;
        if (ValidD === 1'b1 && !stall_now) begin
            vq.push_back(PCD);
            check("instr", InstrD, mem(PCD));
            check("pc_plus4", PCPlus4D, PCD + 32'd4);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        busy     = 1'b0;
        imem_ack = 1'b0;
        cyc();
        cyc();
        reset    = 1'b1;
        vq.delete();
        areq.delete();
        stab_err = 0;
    endtask

    initial begin
        bit found;
        reset = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; imem_ack = 1'b0; imem_rdata = '0;
        busy = 1'b0; cnt = 0; lat = 1; stab_err = 0;

        // Reset state
        do_reset();
        check("rst_req", {31'd0, last_req}, 32'd0);
        check("rst_instr", InstrD, c_nop);
        check("rst_pcd", PCD, 32'd0);
        check("rst_pc4", PCPlus4D, 32'd4);
        check("rst_valid", {31'd0, ValidD}, 32'd0);

        // 1: single-cycle latency, in-order stream
        lat = 1;
        for (int i = 0; i < 10; i++) cyc();
        check("t1_nreq", areq.size(), 5);
        check("t1_nvalid", vq.size(), 4);
        for (int i = 0; i < 3; i++) begin
            if (i < areq.size()) check("t1_addr", areq[i], 32'(i * 4));
            if (i < vq.size())   check("t1_pcd", vq[i], 32'(i * 4));
        end

        // 2: five-cycle latency, one outstanding request, stable address
        do_reset();
        lat = 5;
        for (int i = 0; i < 20; i++) cyc();
        check("t2_stable", stab_err, 0);
        check("t2_nreq", areq.size(), 4);
        check("t2_nvalid", vq.size(), 3);
        for (int i = 0; i < 3; i++) if (i < vq.size()) check("t2_pcd", vq[i], 32'(i * 4));

        // 3: stall fills FIFO, request drops, nothing lost or duplicated
        do_reset();
        lat = 1;
        for (int i = 0; i < 3; i++) cyc();
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("t3_req_drop", {31'd0, last_req}, 32'd0);
        check("t3_hold_pcd", PCD, 32'd0);
        check("t3_hold_valid", {31'd0, ValidD}, 32'd1);
        StallD = 1'b0;
        for (int i = 0; i < 13; i++) cyc();
        check("t3_nvalid_ge6", {31'd0, vq.size() >= 6}, 32'd1);
        for (int i = 0; i < 6; i++) if (i < vq.size()) check("t3_pcd", vq[i], 32'(i * 4));

        // 4: redirect while the request to 0x0C is outstanding
        do_reset();
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc();
            if (busy && raddr == 32'h0C) found = 1'b1;
        end
        check("t4_found", {31'd0, found}, 32'd1);
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        cyc();
        PCSrcE = 1'b0;
        check("t4_valid", {31'd0, ValidD}, 32'd0);
        vq.delete(); areq.delete();
        for (int i = 0; i < 20; i++) cyc();
        if (areq.size() > 0) check("t4_next_addr", areq[0], 32'h100);
        else                 check("t4_nreq", 32'd0, 32'd1);
        if (vq.size() > 1) begin
            check("t4_pcd0", vq[0], 32'h100);
            check("t4_pcd1", vq[1], 32'h104);
        end else check("t4_nvalid", vq.size(), 2);

        // 5: redirect coincides with ack, target low bits masked
        do_reset();
        lat = 1;
        cyc();
        PCSrcE = 1'b1; PCTargetE = 32'h203;
        cyc();
        PCSrcE = 1'b0;
        check("t5_instr", InstrD, c_nop);
        check("t5_valid", {31'd0, ValidD}, 32'd0);
        cyc();
        check("t5_req", {31'd0, last_req}, 32'd1);
        check("t5_addr", last_addr, 32'h200);
        for (int i = 0; i < 4; i++) cyc();
        if (vq.size() > 0) check("t5_pcd", vq[0], 32'h200);
        else               check("t5_nvalid", 32'd0, 32'd1);

        // 6: PC wrap, flush bubble, reset mid-request with late ack
        do_reset();
        lat = 1;
        cyc();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        cyc();
        PCSrcE = 1'b0;
        cyc();
        check("t6_addr_top", last_addr, 32'hFFFF_FFFC);
        cyc();
        cyc();
        check("t6_addr_wrap", last_addr, 32'h0);
        check("t6_pcd_top", PCD, 32'hFFFF_FFFC);
        check("t6_pc4_wrap", PCPlus4D, 32'h0);
        cyc();
        FlushD = 1'b1;
        cyc();
        FlushD = 1'b0;
        check("t6_flush_instr", InstrD, c_nop);
        check("t6_flush_valid", {31'd0, ValidD}, 32'd0);
        cyc();
        check("t6_after_flush_valid", {31'd0, ValidD}, 32'd1);
        check("t6_after_flush_pcd", PCD, 32'h0);
        lat = 4;
        cyc();
        reset = 1'b0;
        cyc();
        check("t6_rst_valid", {31'd0, ValidD}, 32'd0);
        check("t6_rst_pcd", PCD, 32'd0);
        cyc(); cyc(); cyc();
        reset = 1'b1;
        vq.delete();
        cyc();
        check("t6_post_req", {31'd0, last_req}, 32'd1);
        check("t6_post_addr", last_addr, 32'h0);
        for (int i = 0; i < 8; i++) cyc();
        if (vq.size() > 0) check("t6_post_pcd", vq[0], 32'h0);
        else               check("t6_post_nvalid", 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
